// File: rtl/count_wrap_monitor_pkg.sv
// rtl/count_wrap_monitor_pkg.sv - shared state encoding and default widths for the wrap monitor
package count_wrap_monitor_pkg;

   localparam int N_DEFAULT = 4;
   localparam int W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HIT  = 2'd2
   } state_t;

endpackage

// File: rtl/count_wrap_monitor_if.sv
// rtl/count_wrap_monitor_if.sv - counter sample, control and status bundle of the wrap monitor
interface count_wrap_monitor_if
   import count_wrap_monitor_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int W = W_DEFAULT
);

   logic [N-1:0]   Q;
   logic           clr;
   logic           start;
   logic [N+W-1:0] target;
   logic           ack;
   logic [N+W-1:0] ext;
   logic           wrap;
   logic           match;
   logic           ovf;
   logic           busy;

   modport master (
      output Q, clr, start, target, ack,
      input  ext, wrap, match, ovf, busy
   );

   modport slave (
      input  Q, clr, start, target, ack,
      output ext, wrap, match, ovf, busy
   );

endinterface

// File: rtl/count_wrap_monitor_wrap_detector.sv
// rtl/count_wrap_monitor_wrap_detector.sv - holds the previous Q sample and flags wrap or upstream restart
module count_wrap_monitor_wrap_detector #(
   parameter int N = 4
) (
   input  logic         Ck,
   input  logic         reset_,
   input  logic [N-1:0] Q,
   output logic         wrap_now,
   output logic         restart_now
);

   localparam logic [N-1:0] ONES = '1;

   logic [N-1:0] q_prev;

   always_ff @(negedge Ck or negedge reset_) begin
      if (!reset_) begin
         q_prev <= '0;
      end else begin
         q_prev <= Q;
      end
   end

   // A drop to zero from anything but all-ones (or a counter idling at zero) is an upstream reset.
   assign wrap_now    = (q_prev == ONES) && (Q == '0);
   assign restart_now = (Q == '0) && (q_prev != ONES) && (q_prev != '0);

endmodule

// File: rtl/count_wrap_monitor.sv
// rtl/count_wrap_monitor.sv - extends a wrapping counter with a wrap count and flags a target hit
module count_wrap_monitor
   import count_wrap_monitor_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int W = W_DEFAULT
) (
   input  logic                  Ck,
   input  logic                  reset_,
   count_wrap_monitor_if.slave   bus
);

   localparam logic [W-1:0] W_ONES = '1;

   logic           wrap_now;
   logic           restart_now;
   logic [W-1:0]   wcnt;
   logic [W-1:0]   wcnt_next;
   logic           ovf_q;
   logic           ovf_next;
   logic           wrap_q;
   logic [N+W-1:0] ext_q;
   logic [N+W-1:0] ext_next;
   state_t         state;
   state_t         state_next;

   count_wrap_monitor_wrap_detector #(.N(N)) u_wrap_detector (
      .Ck          (Ck),
      .reset_      (reset_),
      .Q           (bus.Q),
      .wrap_now    (wrap_now),
      .restart_now (restart_now)
   );

   // clr outranks both the wrap increment and the restart zeroing; the wrap pulse itself is unaffected.
   always_comb begin
      wcnt_next = wcnt;
      ovf_next  = ovf_q;
      if (bus.clr) begin
         wcnt_next = '0;
         ovf_next  = 1'b0;
      end else if (wrap_now) begin
         wcnt_next = wcnt + W'(1);
         if (wcnt == W_ONES) begin
            ovf_next = 1'b1;
         end
      end else if (restart_now) begin
         wcnt_next = '0;
      end
   end

   assign ext_next = {wcnt_next, bus.Q};

   always_comb begin
      state_next = state;
      if (bus.clr) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start)              state_next = RUN;
            RUN:     if (ext_next >= bus.target) state_next = HIT;
            HIT:     if (bus.ack)                state_next = IDLE;
            default:                             state_next = IDLE;
         endcase
      end
   end

   always_ff @(negedge Ck or negedge reset_) begin
      if (!reset_) begin
         state  <= IDLE;
         wcnt   <= '0;
         ovf_q  <= 1'b0;
         wrap_q <= 1'b0;
         ext_q  <= '0;
      end else begin
         state  <= state_next;
         wcnt   <= wcnt_next;
         ovf_q  <= ovf_next;
         wrap_q <= wrap_now;
         ext_q  <= ext_next;
      end
   end

   assign bus.ext   = ext_q;
   assign bus.wrap  = wrap_q;
   assign bus.ovf   = ovf_q;
   assign bus.match = (state == HIT);
   assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb/tb_count_wrap_monitor.sv - directed and randomized checks of count_wrap_monitor against a reference model
module tb_count_wrap_monitor;

   localparam int N = 4;
   localparam int W = 4;
   localparam int QMAX = (1 << N) - 1;
   localparam int WMOD = 1 << W;

   logic Ck = 1'b0;
   logic reset_;

   count_wrap_monitor_if #(.N(N), .W(W)) bus ();

   count_wrap_monitor #(.N(N), .W(W)) dut (
      .Ck     (Ck),
      .reset_ (reset_),
      .bus    (bus)
   );

   always #5 Ck = ~Ck;

   int checks = 0;
   int errors = 0;

   // reference: number of wraps seen since the last clear/restart, plus a sticky overflow and handshake flags
   int m_qprev = 0;
   int m_wraps = 0;
   int m_ovf   = 0;
   int m_wrap  = 0;
   int m_ext   = 0;
   bit m_run   = 1'b0;
   bit m_hit   = 1'b0;
   int qc      = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ext"},   32'(bus.ext),   32'(m_ext));
      check({tag, ".wrap"},  32'(bus.wrap),  32'(m_wrap));
      check({tag, ".match"}, 32'(bus.match), 32'(m_hit));
      check({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
      check({tag, ".busy"},  32'(bus.busy),  32'(m_run | m_hit));
   endtask

   task automatic model_reset();
      m_qprev = 0;
      m_wraps = 0;
      m_ovf   = 0;
      m_wrap  = 0;
      m_ext   = 0;
      m_run   = 1'b0;
      m_hit   = 1'b0;
   endtask

   task automatic model_edge();
      int  q;
      bit  wrapped;
      bit  restarted;
      q         = int'(bus.Q);
      wrapped   = (m_qprev == QMAX) && (q == 0);
      restarted = (q == 0) && (m_qprev != QMAX) && (m_qprev != 0);
      m_wrap    = wrapped ? 1 : 0;
      if (bus.clr) begin
         m_wraps = 0;
         m_ovf   = 0;
      end else if (wrapped) begin
         m_wraps = m_wraps + 1;
         if (m_wraps == WMOD) begin
            m_wraps = 0;
            m_ovf   = 1;
         end
      end else if (restarted) begin
         m_wraps = 0;
      end
      m_ext = m_wraps * (1 << N) + q;
      if (bus.clr) begin
         m_run = 1'b0;
         m_hit = 1'b0;
      end else if (m_hit) begin
         if (bus.ack) m_hit = 1'b0;
      end else if (m_run) begin
         if (m_ext >= int'(bus.target)) begin
            m_run = 1'b0;
            m_hit = 1'b1;
         end
      end else if (bus.start) begin
         m_run = 1'b1;
      end
      m_qprev = q;
   endtask

   task automatic step(input string tag);
      @(negedge Ck);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic count_step(input string tag);
      qc = (qc + 1) % (QMAX + 1);
      bus.Q = N'(qc);
      step(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int wq[4]   = '{14, 15, 0, 1};
      int wext[4] = '{8'h0E, 8'h0F, 8'h10, 8'h11};
      int wwr[4]  = '{0, 0, 1, 0};
      int n;

      reset_     = 1'b0;
      bus.Q      = N'($urandom);
      bus.clr    = 1'b0;
      bus.start  = 1'b0;
      bus.ack    = 1'b0;
      bus.target = '0;
      model_reset();
      #1;
      check_all("reset_initial");
      @(posedge Ck);
      bus.Q  = '0;
      reset_ = 1'b1;

      // wrap pulse and extended count
      for (int i = 0; i < 4; i++) begin
         bus.Q = N'(wq[i]);
         step("wrap_seq");
         check("wrap_seq.ext_const", 32'(bus.ext), 32'(wext[i]));
         check("wrap_seq.wrap_const", 32'(bus.wrap), 32'(wwr[i]));
      end
      qc = 1;

      // match handshake at target 0x13
      bus.clr = 1'b1;
      qc = 0;
      bus.Q = '0;
      step("clr_before_match");
      bus.clr    = 1'b0;
      bus.target = 8'h13;
      bus.start  = 1'b1;
      count_step("arm");
      bus.start  = 1'b0;
      check("arm.busy_const", 32'(bus.busy), 32'd1);
      n = 0;
      while (!m_hit && n < 40) begin
         count_step("run_to_match");
         n++;
      end
      check("match.rise_ext", 32'(bus.ext), 32'h13);
      check("match.rise", 32'(bus.match), 32'd1);
      for (int i = 0; i < 5; i++) begin
         count_step("match_hold");
         check("match_hold.const", 32'(bus.match), 32'd1);
      end
      bus.ack = 1'b1;
      count_step("ack");
      bus.ack = 1'b0;
      check("ack.match_const", 32'(bus.match), 32'd0);
      check("ack.busy_const", 32'(bus.busy), 32'd0);

      // 16 full wraps from a cleared wrap counter
      bus.clr = 1'b1;
      count_step("clr_before_ovf");
      bus.clr = 1'b0;
      for (int i = 0; i < 16 * (QMAX + 1); i++) count_step("ovf_run");
      check("ovf.set_const", 32'(bus.ovf), 32'd1);
      check("ovf.wcnt_zero", 32'(bus.ext[N+W-1:N]), 32'd0);

      // upstream restart with wcnt=3 and ovf still set
      n = 0;
      while (m_ext != 8'h37 && n < 100) begin
         count_step("to_restart");
         n++;
      end
      check("restart.pre_ext", 32'(bus.ext), 32'h37);
      qc = 0;
      bus.Q = '0;
      step("restart");
      check("restart.wrap_const", 32'(bus.wrap), 32'd0);
      check("restart.ext_const", 32'(bus.ext), 32'h00);
      check("restart.ovf_const", 32'(bus.ovf), 32'd1);
      bus.clr = 1'b1;
      count_step("ovf_clr");
      bus.clr = 1'b0;
      check("ovf_clr.ovf_const", 32'(bus.ovf), 32'd0);
      check("ovf_clr.upper_const", 32'(bus.ext[N+W-1:N]), 32'd0);

      // all-ones target matches only at ext=0xFF
      bus.target = 8'hFF;
      bus.start  = 1'b1;
      count_step("arm_ff");
      bus.start  = 1'b0;
      n = 0;
      while (!m_hit && n < 300) begin
         count_step("run_to_ff");
         n++;
      end
      check("ff.ext_const", 32'(bus.ext), 32'hFF);
      check("ff.match_const", 32'(bus.match), 32'd1);
      bus.ack = 1'b1;
      count_step("ack_ff");
      bus.ack = 1'b0;

      // target zero, then clr+ack in HIT and clr+start in IDLE
      bus.target = '0;
      bus.start  = 1'b1;
      count_step("arm_zero");
      bus.start  = 1'b0;
      count_step("zero_hit");
      check("zero_hit.match_const", 32'(bus.match), 32'd1);
      bus.clr = 1'b1;
      bus.ack = 1'b1;
      count_step("clr_ack");
      bus.ack = 1'b0;
      check("clr_ack.match_const", 32'(bus.match), 32'd0);
      bus.start = 1'b1;
      count_step("clr_start");
      bus.start = 1'b0;
      bus.clr   = 1'b0;
      check("clr_start.busy_const", 32'(bus.busy), 32'd0);

      // wrap coinciding with clr
      qc = 14;
      count_step("pre_wrap_clr");
      bus.clr = 1'b1;
      count_step("wrap_clr");
      bus.clr = 1'b0;
      check("wrap_clr.wrap_const", 32'(bus.wrap), 32'd1);
      check("wrap_clr.ext_const", 32'(bus.ext), 32'h00);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         if (i % 50 == 0) bus.target = (N+W)'($urandom);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.ack   = ($urandom_range(0, 3) == 0);
         bus.clr   = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 7) == 0) begin
            qc = $urandom_range(0, QMAX);
            bus.Q = N'(qc);
            step("random");
         end else begin
            count_step("random");
         end
      end
      bus.start = 1'b0;
      bus.ack   = 1'b0;
      bus.clr   = 1'b0;

      // reset asserted between edges
      bus.target = '0;
      bus.start  = 1'b1;
      count_step("pre_reset");
      bus.start  = 1'b0;
      count_step("pre_reset");
      @(posedge Ck);
      #2;
      reset_ = 1'b0;
      bus.Q  = N'($urandom);
      model_reset();
      #1;
      check_all("reset_async");
      @(negedge Ck);
      #1;
      check_all("reset_hold");
      @(posedge Ck);
      reset_ = 1'b1;
      qc = 0;
      bus.Q = '0;
      for (int i = 0; i < 20; i++) count_step("post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
